// File: rtl/axi4_slave_ram.sv
// AXI4 responder backed by a word-addressed RAM with independent read and write FSMs.
// Supports FIXED/INCR/WRAP bursts on a 32-bit bus; bad size/burst/wlast yields SLVERR.
module axi4_slave_ram #(
    parameter int MEM_AW    = 10,
    parameter bit INIT_ZERO = 1'b0
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_awaddr,
    input  logic [7:0]  s_axi_awlen,
    input  logic [2:0]  s_axi_awsize,
    input  logic [1:0]  s_axi_awburst,
    input  logic        s_axi_awlock,
    input  logic [3:0]  s_axi_awcache,
    input  logic [2:0]  s_axi_awprot,
    input  logic [3:0]  s_axi_awqos,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wlast,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    output logic [1:0]  s_axi_bresp,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    input  logic [31:0] s_axi_araddr,
    input  logic [7:0]  s_axi_arlen,
    input  logic [2:0]  s_axi_arsize,
    input  logic [1:0]  s_axi_arburst,
    input  logic        s_axi_arlock,
    input  logic [3:0]  s_axi_arcache,
    input  logic [2:0]  s_axi_arprot,
    input  logic [3:0]  s_axi_arqos,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rlast,
    output logic [1:0]  dbg_wstate,
    output logic [1:0]  dbg_rstate
);
    // Handshake rule on every channel: a transfer happens on the rising edge where
    // valid and ready are both 1; a source holds its payload stable until then.
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

    localparam int DEPTH = 1 << MEM_AW;

    // Zero fill is also a valid realisation of "undefined" contents.
    logic [31:0] mem [DEPTH] = '{default: (INIT_ZERO ? 32'h0 : 32'hx)};

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    function automatic logic bad_req(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [7:0] len);
        return (size != 3'b010) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok(len));
    endfunction

    // An illegal WRAP length runs as INCR so the address still walks sensibly.
    function automatic logic [1:0] eff_burst(input logic [1:0] burst, input logic [7:0] len);
        return ((burst == 2'b10) && !wrap_len_ok(len)) ? 2'b01 : burst;
    endfunction

    function automatic logic [MEM_AW-1:0] next_addr(input logic [MEM_AW-1:0] addr,
                                                    input logic [1:0] burst,
                                                    input logic [7:0] len);
        logic [MEM_AW-1:0] mask;
        logic [MEM_AW-1:0] inc;
        logic [MEM_AW-1:0] nxt;
        mask = MEM_AW'(len);
        inc  = addr + MEM_AW'(1);
        case (burst)
            2'b00:   nxt = addr;
            2'b10:   nxt = (addr & ~mask) | (inc & mask);
            default: nxt = inc;
        endcase
        return nxt;
    endfunction

    wstate_t           wstate_q, wstate_d;
    logic [MEM_AW-1:0] waddr_q, waddr_d;
    logic [7:0]        wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [1:0]        wburst_q, wburst_d;
    logic              werr_q, werr_d;
    logic              mem_we;

    always_comb begin
        wstate_d = wstate_q;
        waddr_d  = waddr_q;
        wlen_d   = wlen_q;
        wcnt_d   = wcnt_q;
        wburst_d = wburst_q;
        werr_d   = werr_q;
        mem_we   = 1'b0;
        case (wstate_q)
            W_IDLE: if (s_axi_awvalid) begin
                waddr_d  = s_axi_awaddr[MEM_AW+1:2];
                wlen_d   = s_axi_awlen;
                wburst_d = eff_burst(s_axi_awburst, s_axi_awlen);
                werr_d   = bad_req(s_axi_awsize, s_axi_awburst, s_axi_awlen);
                wcnt_d   = 8'd0;
                wstate_d = W_DATA;
            end
            W_DATA: if (s_axi_wvalid) begin
                mem_we  = !werr_q;
                if (s_axi_wlast != (wcnt_q == wlen_q)) werr_d = 1'b1;
                waddr_d = next_addr(waddr_q, wburst_q, wlen_q);
                wcnt_d  = wcnt_q + 8'd1;
                if (wcnt_q == wlen_q) wstate_d = W_RESP;
            end
            W_RESP: if (s_axi_bready) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && s_axi_wstrb[i]) mem[waddr_q][8*i +: 8] <= s_axi_wdata[8*i +: 8];
        end
    end

    rstate_t           rstate_q, rstate_d;
    logic [MEM_AW-1:0] raddr_q, raddr_d;
    logic [7:0]        rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [1:0]        rburst_q, rburst_d;
    logic              rerr_q, rerr_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              rlast_q, rlast_d;

    always_comb begin
        rstate_d = rstate_q;
        raddr_d  = raddr_q;
        rlen_d   = rlen_q;
        rcnt_d   = rcnt_q;
        rburst_d = rburst_q;
        rerr_d   = rerr_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rlast_d  = rlast_q;
        case (rstate_q)
            R_IDLE: if (s_axi_arvalid) begin
                raddr_d  = s_axi_araddr[MEM_AW+1:2];
                rlen_d   = s_axi_arlen;
                rburst_d = eff_burst(s_axi_arburst, s_axi_arlen);
                rerr_d   = bad_req(s_axi_arsize, s_axi_arburst, s_axi_arlen);
                rcnt_d   = 8'd0;
                rstate_d = R_FETCH;
            end
            R_FETCH: begin
                // Registered RAM read; a write on the same edge lands after this sample.
                rdata_d  = rerr_q ? 32'h0 : mem[raddr_q];
                rresp_d  = rerr_q ? 2'b10 : 2'b00;
                rlast_d  = (rcnt_q == rlen_q);
                rstate_d = R_DATA;
            end
            R_DATA: if (s_axi_rready) begin
                if (rlast_q) begin
                    rlast_d  = 1'b0;
                    rstate_d = R_IDLE;
                end else begin
                    raddr_d  = next_addr(raddr_q, rburst_q, rlen_q);
                    rcnt_d   = rcnt_q + 8'd1;
                    rstate_d = R_FETCH;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wstate_q <= W_IDLE;
            waddr_q  <= '0;
            wlen_q   <= '0;
            wcnt_q   <= '0;
            wburst_q <= '0;
            werr_q   <= 1'b0;
            rstate_q <= R_IDLE;
            raddr_q  <= '0;
            rlen_q   <= '0;
            rcnt_q   <= '0;
            rburst_q <= '0;
            rerr_q   <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= '0;
            rlast_q  <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            waddr_q  <= waddr_d;
            wlen_q   <= wlen_d;
            wcnt_q   <= wcnt_d;
            wburst_q <= wburst_d;
            werr_q   <= werr_d;
            rstate_q <= rstate_d;
            raddr_q  <= raddr_d;
            rlen_q   <= rlen_d;
            rcnt_q   <= rcnt_d;
            rburst_q <= rburst_d;
            rerr_q   <= rerr_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rlast_q  <= rlast_d;
        end
    end

    assign s_axi_awready = (wstate_q == W_IDLE);
    assign s_axi_wready  = (wstate_q == W_DATA);
    assign s_axi_bvalid  = (wstate_q == W_RESP);
    assign s_axi_bresp   = (s_axi_bvalid && werr_q) ? 2'b10 : 2'b00;
    assign s_axi_arready = (rstate_q == R_IDLE);
    assign s_axi_rvalid  = (rstate_q == R_DATA);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rlast   = rlast_q;
    assign dbg_wstate    = wstate_q;
    assign dbg_rstate    = rstate_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                         s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos,
                         s_axi_awaddr[31:MEM_AW+2], s_axi_awaddr[1:0],
                         s_axi_araddr[31:MEM_AW+2], s_axi_araddr[1:0]};
endmodule

// File: tb/tb_axi4_slave_ram.sv
// Directed bench for axi4_slave_ram: writes bursts, reads them back, and compares
// read data/responses against expectations queued when each transaction is issued.
module tb_axi4_slave_ram;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        awvalid = 0, awready, wvalid = 0, wready, wlast = 0;
    logic        bvalid, bready = 0, arvalid = 0, arready, rvalid, rready = 0, rlast;
    logic [31:0] awaddr = 0, araddr = 0, wdata = 0, rdata;
    logic [7:0]  awlen = 0, arlen = 0;
    logic [2:0]  awsize = 3'b010, arsize = 3'b010;
    logic [1:0]  awburst = 2'b01, arburst = 2'b01, bresp, rresp, dbg_wstate, dbg_rstate;
    logic [3:0]  wstrb = 4'hF;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [1:0]  exp_b_q[$];
    logic [1:0]  exp_r_q[$];
    logic [31:0] wbuf [256];

    always #5 aclk = ~aclk;

    axi4_slave_ram #(.MEM_AW(10), .INIT_ZERO(1'b1)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
        .s_axi_awlen(awlen), .s_axi_awsize(awsize), .s_axi_awburst(awburst),
        .s_axi_awlock(1'b0), .s_axi_awcache(4'h0), .s_axi_awprot(3'h0), .s_axi_awqos(4'h0),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata),
        .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
        .s_axi_arlen(arlen), .s_axi_arsize(arsize), .s_axi_arburst(arburst),
        .s_axi_arlock(1'b0), .s_axi_arcache(4'h0), .s_axi_arprot(3'h0), .s_axi_arqos(4'h0),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata),
        .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .dbg_wstate(dbg_wstate), .dbg_rstate(dbg_rstate)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_aw(input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        for (int i = 0; i < 50 && awready !== 1'b1; i++) tick();
        chk("awready", awready, 1);
        tick();
        awvalid = 1'b0;
        chk("aw_to_wready", wready, 1);
    endtask

    task automatic do_w(input logic [7:0] len, input logic [3:0] strb, input int last_beat);
        for (int b = 0; b <= int'(len); b++) begin
            wvalid = 1'b1; wdata = wbuf[b]; wstrb = strb; wlast = (b == last_beat);
            for (int i = 0; i < 50 && wready !== 1'b1; i++) tick();
            chk("wready", wready, 1);
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("w_to_bvalid", bvalid, 1);
    endtask

    task automatic do_b();
        bready = 1'b1;
        for (int i = 0; i < 50 && bvalid !== 1'b1; i++) tick();
        chk("bvalid", bvalid, 1);
        chk("bresp", bresp, exp_b_q.pop_front());
        tick();
        bready = 1'b0;
        chk("awready_after_b", awready, 1);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                      input logic [1:0] burst, input logic [3:0] strb, input int last_beat,
                      input logic [1:0] exp_resp);
        exp_b_q.push_back(exp_resp);
        do_aw(addr, len, size, burst);
        do_w(len, strb, last_beat);
        do_b();
    endtask

    task automatic do_ar(input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        for (int i = 0; i < 50 && arready !== 1'b1; i++) tick();
        chk("arready", arready, 1);
        tick();
        arvalid = 1'b0;
        chk("r_latency_c1", rvalid, 0);
        tick();
        chk("r_latency_c2", rvalid, 1);
    endtask

    task automatic do_r(input logic [7:0] len, input bit stall);
        logic [31:0] hold;
        for (int b = 0; b <= int'(len); b++) begin
            for (int i = 0; i < 50 && rvalid !== 1'b1; i++) tick();
            chk("rvalid", rvalid, 1);
            if (stall) begin
                hold = rdata;
                tick();
                chk("rvalid_stall", rvalid, 1);
                chk("rdata_stable", rdata, hold);
            end
            rready = 1'b1;
            chk("rdata", rdata, exp_q.pop_front());
            chk("rresp", rresp, exp_r_q.pop_front());
            chk("rlast", rlast, b == int'(len));
            tick();
            rready = 1'b0;
        end
        chk("arready_after_r", arready, 1);
    endtask

    task automatic expect_rd(input logic [31:0] data, input logic [1:0] resp);
        exp_q.push_back(data);
        exp_r_q.push_back(resp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge aclk);
        #3 aresetn = 1'b1;
        tick();
        chk("rst_awready", awready, 1);
        chk("rst_arready", arready, 1);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rresp", rresp, 0);

        // Single word write and read
        wbuf[0] = 32'hDEADBEEF;
        wr(32'h10, 8'd0, 3'b010, 2'b01, 4'hF, 0, 2'b00);
        expect_rd(32'hDEADBEEF, 2'b00);
        do_ar(32'h10, 8'd0, 3'b010, 2'b01);
        do_r(8'd0, 1'b0);

        // INCR burst, read back with stalls
        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        wr(32'h100, 8'd3, 3'b010, 2'b01, 4'hF, 3, 2'b00);
        for (int i = 0; i < 4; i++) expect_rd(32'(i + 1), 2'b00);
        do_ar(32'h100, 8'd3, 3'b010, 2'b01);
        do_r(8'd3, 1'b1);

        // Byte strobes
        wbuf[0] = 32'hFFFFFFFF;
        wr(32'h40, 8'd0, 3'b010, 2'b01, 4'hF, 0, 2'b00);
        wbuf[0] = 32'h00000000;
        wr(32'h40, 8'd0, 3'b010, 2'b01, 4'b0101, 0, 2'b00);
        expect_rd(32'hFF00FF00, 2'b00);
        do_ar(32'h40, 8'd0, 3'b010, 2'b01);
        do_r(8'd0, 1'b0);

        // WRAP len 3 starting mid-block
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0A0_0000 + 32'(i);
        wr(32'h208, 8'd3, 3'b010, 2'b10, 4'hF, 3, 2'b00);
        expect_rd(32'hA0A0_0002, 2'b00);
        expect_rd(32'hA0A0_0003, 2'b00);
        expect_rd(32'hA0A0_0000, 2'b00);
        expect_rd(32'hA0A0_0001, 2'b00);
        do_ar(32'h200, 8'd3, 3'b010, 2'b01);
        do_r(8'd3, 1'b0);

        // Unsupported awsize: SLVERR, RAM unchanged
        wbuf[0] = 32'h12345678;
        wr(32'h10, 8'd0, 3'b001, 2'b01, 4'hF, 0, 2'b10);
        expect_rd(32'hDEADBEEF, 2'b00);
        do_ar(32'h10, 8'd0, 3'b010, 2'b01);
        do_r(8'd0, 1'b0);

        // Early wlast: all four beats still consumed, SLVERR
        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 5);
        wr(32'h300, 8'd3, 3'b010, 2'b01, 4'hF, 1, 2'b10);

        // Reserved read burst
        expect_rd(32'h0, 2'b10);
        do_ar(32'h10, 8'd0, 3'b010, 2'b11);
        do_r(8'd0, 1'b0);

        // FIXED burst overwrites one word; next word still zero
        wbuf[0] = 32'h11; wbuf[1] = 32'h22;
        wr(32'h50, 8'd1, 3'b010, 2'b00, 4'hF, 1, 2'b00);
        expect_rd(32'h22, 2'b00);
        expect_rd(32'h0, 2'b00);
        do_ar(32'h50, 8'd1, 3'b010, 2'b01);
        do_r(8'd1, 1'b0);

        // Async reset mid read burst
        do_ar(32'h100, 8'd3, 3'b010, 2'b01);
        #2 aresetn = 1'b0;
        #1;
        chk("rst_mid_rvalid", rvalid, 0);
        chk("rst_mid_rlast", rlast, 0);
        #3 aresetn = 1'b1;
        tick();
        chk("post_rst_arready", arready, 1);
        expect_rd(32'hDEADBEEF, 2'b00);
        do_ar(32'h10, 8'd0, 3'b010, 2'b01);
        do_r(8'd0, 1'b0);

        chk("queues_empty", 32'(exp_q.size() + exp_r_q.size() + exp_b_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi4_slave_ram.md
Name: axi4_slave_ram

Overview:
AXI4 memory-mapped responder backed by an internal word-addressed RAM. It is the far-end target for the UART-to-AXI4 master bridge, and pairs with that bridge in system and loopback benches. It also serves as a scratch/debug memory in the design. Independent read and write channels are supported, with FIXED/INCR/WRAP bursts up to 256 beats on a 32-bit data bus.

Parameters:
MEM_AW, 10, log2 of RAM depth in 32-bit words (default 1024 words = 4 KiB)
INIT_ZERO, 0, 1 = clear RAM at elaboration; 0 = contents undefined at power-up

Ports:
aclk  input  1  clock
aresetn  input  1  asynchronous active-low reset
s_axi_awvalid / s_axi_awready  input / output  1 / 1  write-address handshake
s_axi_awaddr  input  32  byte address; word index = awaddr[MEM_AW+1:2]; upper bits alias
s_axi_awlen  input  8  beats minus 1
s_axi_awsize  input  3  only 3'b010 supported
s_axi_awburst  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
s_axi_awlock / awcache / awprot / awqos  input  1/4/3/4  accepted, ignored
s_axi_wvalid / s_axi_wready  input / output  1 / 1  write-data handshake
s_axi_wdata / s_axi_wstrb / s_axi_wlast  input  32/4/1  write beat
s_axi_bvalid / s_axi_bready  output / input  1 / 1  write-response handshake
s_axi_bresp  output  2  00 OKAY, 10 SLVERR
s_axi_arvalid / s_axi_arready  input / output  1 / 1  read-address handshake
s_axi_araddr / arlen / arsize / arburst  input  32/8/3/2  same rules as AW
s_axi_arlock / arcache / arprot / arqos  input  1/4/3/4  accepted, ignored
s_axi_rvalid / s_axi_rready  output / input  1 / 1  read-data handshake
s_axi_rdata / s_axi_rresp / s_axi_rlast  output  32/2/1  read beat

Behaviour:
- Reset (aresetn low, async): both FSMs go idle. bvalid, rvalid, rlast and wready = 0; rdata = 0; bresp = rresp = 00. RAM is not reset.
- awready = (wstate==W_IDLE); arready = (rstate==R_IDLE). Both are 1 from the first cycle after reset release.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: on awvalid&awready, latch addr, len, burst, err. err = (awsize!=010) | (awburst==11). Clear beat counter.
  - W_DATA: wready=1. Each wvalid&wready beat writes RAM bytes where wstrb[i]=1, unless err. The counter increments each beat.
  - Protocol error: wlast high before beat awlen, or low on beat awlen, sets err (SLVERR). Exactly awlen+1 beats are consumed regardless of wlast.
  - After beat awlen, go to W_RESP.
  - W_RESP: bvalid=1, bresp = err ? 10 : 00. Hold until bready, then W_IDLE. AW→first W accept is 1 cycle; last W→bvalid is 1 cycle.
- Read FSM R_IDLE -> R_FETCH -> R_DATA -> (R_FETCH | R_IDLE):
  - R_IDLE: on arvalid&arready, latch params and err (same rule as writes).
  - R_FETCH: synchronous RAM read of current address (1 cycle).
  - R_DATA: rvalid=1. rdata = RAM word (0 if err). rresp = err ? 10 : 00. rlast = (beat==arlen).
  - rdata, rresp and rlast hold stable until rready. On handshake: R_IDLE if last, else advance address and go to R_FETCH.
  - First rvalid is 2 cycles after AR handshake; throughput is 1 beat per 2 cycles minimum.
- Address update per beat: FIXED unchanged; INCR +4, wraps modulo RAM size; WRAP: +4 within aligned block of (len+1)*4 bytes, wrapping to the block base. For WRAP with len not in {1,3,7,15}, err is set and the burst is treated as INCR.
- Read and write run concurrently. A same-cycle read and write to the same word returns old data (read-before-write).
- Back-to-back: a new AW is accepted only after B handshake completes; a new AR only after the final R handshake.
- Async reset mid-burst aborts the burst. Partially written beats remain in RAM, and no response is issued.

Test Plan:
- Single write then read: AW addr 0x10, len 0, wdata 0xDEADBEEF, strb F -> bresp 00; AR 0x10 -> rdata 0xDEADBEEF, rlast 1, rresp 00, rvalid 2 cycles after AR.
- INCR burst len 3 at 0x100, data 1..4, then read back with rready toggling every other cycle -> data 1,2,3,4 in order, rlast only on beat 4, rdata stable while stalled.
- Byte strobes: write 0xFFFFFFFF, then 0x00000000 with strb 0101 -> readback 0xFF00FF00.
- WRAP len 3 at 0x208 -> writes words 0x208, 0x20C, 0x200, 0x204; INCR readback from 0x200 confirms order.
- Errors: awsize 001 -> no RAM change, bresp 10. Write with wlast on beat 1 of len-3 burst -> 4 beats consumed, bresp 10. AR burst 11 -> rresp 10, rdata 0.
- Reset asserted mid read burst -> rvalid drops immediately; after release arready=1 and a new read completes normally.
